// File: rtl/fifo_write_arbiter_pkg.sv
// Shared types and the round-robin search used by the FIFO write arbiter.
package fifo_arb_pkg;

    typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_e;

    localparam int unsigned MAX_REQ   = 32;
    localparam int unsigned MAX_IDX_W = 5;

    // First set bit of valid strictly after ptr, wrapping at n; returns ptr when none is set.
    function automatic int unsigned rr_next(input logic [MAX_REQ-1:0] valid,
                                            input int unsigned ptr,
                                            input int unsigned n);
        int unsigned pick;
        int unsigned idx;
        logic        found;
        pick  = ptr;
        found = 1'b0;
        for (int unsigned i = 1; i <= MAX_REQ; i++) begin
            if (i <= n) begin
                idx = (ptr + i) % n;
                if (!found && valid[idx[MAX_IDX_W-1:0]]) begin
                    pick  = idx;
                    found = 1'b1;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/fifo_write_arbiter_if.sv
// Producer-side stream bus, FIFO write port and arbiter status, bundled for the arbiter.
interface fifo_write_arbiter_if #(
    parameter int unsigned NUM_REQ = 4
);
    import fifo_arb_pkg::*;

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] i_req_valid;
    logic [NUM_REQ-1:0] i_req_data;
    logic [NUM_REQ-1:0] i_req_last;
    logic [NUM_REQ-1:0] o_req_ready;
    logic               o_fifo_data;
    logic               o_fifo_write;
    logic               i_fifo_full;
    logic [NUM_REQ-1:0] o_grant;
    logic [IDX_W-1:0]   o_grant_idx;
    logic               o_busy;
    logic               o_abort;

    // Producers and the FIFO drive the inputs.
    modport master (
        output i_req_valid, i_req_data, i_req_last, i_fifo_full,
        input  o_req_ready, o_fifo_data, o_fifo_write, o_grant, o_grant_idx, o_busy, o_abort
    );

    // The arbiter itself.
    modport slave (
        input  i_req_valid, i_req_data, i_req_last, i_fifo_full,
        output o_req_ready, o_fifo_data, o_fifo_write, o_grant, o_grant_idx, o_busy, o_abort
    );

endinterface

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Combinational round-robin selector: first valid index after the pointer, wrapping.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [IDX_W-1:0]   pick_o,
    output logic               any_o
);

    logic [MAX_REQ-1:0] valid_ext;

    generate
        for (genvar gi = 0; gi < MAX_REQ; gi++) begin : g_ext
            if (gi < NUM_REQ) begin : g_used
                assign valid_ext[gi] = valid_i[gi];
            end else begin : g_pad
                assign valid_ext[gi] = 1'b0;
            end
        end
    endgenerate

    always_comb begin
        pick_o = IDX_W'(rr_next(valid_ext, 32'(ptr_i), NUM_REQ));
    end

    assign any_o = |valid_i;

endmodule

// File: rtl/fifo_write_arbiter.sv
// Frame-granular round-robin arbiter sharing one bit-wide FIFO write port among NUM_REQ
// producers, with an optional mid-frame stall timeout that aborts the frame.
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned STALL_TIMEOUT = 64
) (
    input logic                 i_clk,
    input logic                 i_reset,
    fifo_write_arbiter_if.slave bus
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned TMO_W = (STALL_TIMEOUT > 0) ? $clog2(STALL_TIMEOUT + 1) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((STALL_TIMEOUT > 0) ? STALL_TIMEOUT - 1 : 0);
    localparam logic [IDX_W-1:0] PTR_RST  = IDX_W'(NUM_REQ - 1);
    localparam logic             TMO_ON   = (STALL_TIMEOUT != 0);

    arb_state_e         state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [TMO_W-1:0]   stall_q, stall_d;
    logic               abort_q, abort_d;

    logic [IDX_W-1:0]   pick;
    logic               any_valid;
    logic               busy;
    logic               cur_valid;
    logic               cur_data;
    logic               cur_last;
    logic               hs;
    logic [NUM_REQ-1:0] grant_oh;

    // The grant index doubles as the round-robin pointer.
    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .valid_i (bus.i_req_valid),
        .ptr_i   (idx_q),
        .pick_o  (pick),
        .any_o   (any_valid)
    );

    assign busy      = (state_q == ARB_BUSY);
    assign cur_valid = bus.i_req_valid[idx_q];
    assign cur_data  = bus.i_req_data[idx_q];
    assign cur_last  = bus.i_req_last[idx_q];
    assign hs        = busy & cur_valid & ~bus.i_fifo_full;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_grant
            assign grant_oh[gi] = busy & (idx_q == IDX_W'(gi));
        end
    endgenerate

    assign bus.o_grant      = grant_oh;
    assign bus.o_req_ready  = bus.i_fifo_full ? '0 : grant_oh;
    assign bus.o_fifo_write = hs;
    assign bus.o_fifo_data  = busy & cur_data;
    assign bus.o_grant_idx  = idx_q;
    assign bus.o_busy       = busy;
    assign bus.o_abort      = abort_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        stall_d = stall_q;
        abort_d = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (any_valid) begin
                    state_d = ARB_BUSY;
                    idx_d   = pick;
                    stall_d = '0;
                end
            end
            ARB_BUSY: begin
                if (hs) begin
                    stall_d = '0;
                    if (cur_last) begin
                        state_d = ARB_IDLE;
                    end
                end else if (TMO_ON && !cur_valid && !bus.i_fifo_full) begin
                    // Only a silent producer counts as a stall; a full FIFO just holds the count.
                    if (stall_q == TMO_LAST) begin
                        state_d = ARB_IDLE;
                        abort_d = 1'b1;
                        stall_d = '0;
                    end else begin
                        stall_d = stall_q + TMO_W'(1);
                    end
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= ARB_IDLE;
            idx_q   <= PTR_RST;
            stall_q <= '0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            stall_q <= stall_d;
            abort_q <= abort_d;
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed and random checks of fifo_write_arbiter against a per-producer bit scoreboard.
module tb_fifo_write_arbiter;

    localparam int N   = 4;
    localparam int TMO = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fifo_write_arbiter_if #(.NUM_REQ(N)) bus ();

    fifo_write_arbiter #(.NUM_REQ(N), .STALL_TIMEOUT(TMO)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Entries are {last, data}; tx_q feeds the drivers, exp_q is what the FIFO must receive.
    bit [1:0]     tx_q  [N][$];
    bit [1:0]     exp_q [N][$];
    bit           hold  [N];
    bit           full_cfg;
    bit           stress;
    int           wr_cnt;
    int           abort_cnt;
    int           bubble_viol;
    int           owner;
    logic [N-1:0] prev_grant;
    int           grant_log[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic queue_frame(input int p, input logic [31:0] bits, input int len);
        bit [1:0] e;
        for (int i = 0; i < len; i++) begin
            e = {(i == len - 1), bits[len-1-i]};
            tx_q[p].push_back(e);
            exp_q[p].push_back(e);
        end
    endtask

    task automatic flush(input int p);
        tx_q[p].delete();
        exp_q[p].delete();
    endtask

    task automatic drive_idle();
        bus.i_req_valid = '0;
        bus.i_req_data  = '0;
        bus.i_req_last  = '0;
        bus.i_fifo_full = 1'b0;
    endtask

    function automatic bit all_done();
        bit d;
        d = !bus.o_busy;
        for (int p = 0; p < N; p++) if (tx_q[p].size() != 0) d = 1'b0;
        return d;
    endfunction

    task automatic clear_monitor();
        owner      = -1;
        prev_grant = '0;
        grant_log.delete();
        wr_cnt      = 0;
        abort_cnt   = 0;
        bubble_viol = 0;
    endtask

    task automatic apply_reset();
        drive_idle();
        full_cfg = 1'b0;
        rst = 1'b1;
        for (int p = 0; p < N; p++) begin
            flush(p);
            hold[p] = 1'b0;
        end
        clear_monitor();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // One clock: drive after the rising edge, observe and score at the falling edge.
    task automatic cycle();
        logic [N-1:0] v, d, l;
        bit [1:0]     e;
        int           p;
        @(posedge clk);
        #1;
        v = '0; d = '0; l = '0;
        for (int q = 0; q < N; q++) begin
            if (tx_q[q].size() != 0 && !hold[q]) begin
                v[q] = 1'b1;
                d[q] = tx_q[q][0][0];
                l[q] = tx_q[q][0][1];
            end
        end
        bus.i_req_valid = v;
        bus.i_req_data  = d;
        bus.i_req_last  = l;
        bus.i_fifo_full = stress ? ($urandom_range(0, 99) < 30) : full_cfg;
        @(negedge clk);
        if (bus.o_fifo_write) begin
            p = int'(bus.o_grant_idx);
            wr_cnt++;
            check("no_write_when_full", 32'(bus.i_fifo_full), 0);
            if (owner >= 0) check("frame_owner", p, owner);
            check("sb_has_entry", 32'(exp_q[p].size() != 0), 1);
            if (exp_q[p].size() != 0) begin
                e = exp_q[p].pop_front();
                check("write_bit", 32'(bus.o_fifo_data), 32'(e[0]));
                owner = e[1] ? -1 : p;
                $display("tb: write producer=%0d bit=%0b last=%0b", p, bus.o_fifo_data, e[1]);
            end
        end
        if (bus.o_abort) begin
            abort_cnt++;
            owner = -1;
            $display("tb: abort observed");
        end
        if (bus.o_grant != '0 && prev_grant == '0) grant_log.push_back(int'(bus.o_grant_idx));
        if (bus.o_grant != '0 && prev_grant != '0 && bus.o_grant != prev_grant) bubble_viol++;
        for (int q = 0; q < N; q++) begin
            if (bus.i_req_valid[q] && bus.o_req_ready[q] && tx_q[q].size() != 0) void'(tx_q[q].pop_front());
        end
        prev_grant = bus.o_grant;
    endtask

    initial begin
        int total;
        stress   = 1'b0;
        full_cfg = 1'b0;
        for (int p = 0; p < N; p++) hold[p] = 1'b0;
        clear_monitor();
        drive_idle();
        rst = 1'b1;
        #3;
        check("rst_grant", 32'(bus.o_grant), 0);
        check("rst_busy", 32'(bus.o_busy), 0);
        check("rst_abort", 32'(bus.o_abort), 0);
        check("rst_write", 32'(bus.o_fifo_write), 0);
        check("rst_ready", 32'(bus.o_req_ready), 0);
        check("rst_grant_idx", 32'(bus.o_grant_idx), N - 1);
        @(posedge clk);
        #1 rst = 1'b0;

        // 1: single 5-bit frame 10110 from producer 0
        queue_frame(0, 32'b10110, 5);
        cycle();
        check("t1_no_grant_first_cycle", 32'(bus.o_grant), 0);
        check("t1_no_write_idle", 32'(bus.o_fifo_write), 0);
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("t1_grant0", 32'(bus.o_grant), 32'h1);
            check("t1_write_consecutive", 32'(bus.o_fifo_write), 1);
        end
        cycle();
        check("t1_idle_after", 32'(bus.o_busy), 0);
        check("t1_grant_cleared", 32'(bus.o_grant), 0);
        check("t1_write_count", wr_cnt, 5);

        // 2: all producers with 2-bit frames, producer 0 has a second one
        apply_reset();
        for (int p = 0; p < N; p++) queue_frame(p, p, 2);
        queue_frame(0, 32'b11, 2);
        for (int k = 0; k < 60 && !all_done(); k++) cycle();
        check("t2_done", 32'(all_done()), 1);
        check("t2_write_count", wr_cnt, 10);
        check("t2_bubbles", bubble_viol, 0);
        check("t2_grant_count", grant_log.size(), 5);
        for (int i = 0; i < 5; i++) check("t2_grant_order", grant_log[i], i % N);

        // 2b: single-bit frame occupies BUSY for exactly one cycle
        apply_reset();
        queue_frame(1, 32'b1, 1);
        cycle();
        check("t2b_idle", 32'(bus.o_busy), 0);
        cycle();
        check("t2b_grant1", 32'(bus.o_grant), 32'h2);
        check("t2b_write", 32'(bus.o_fifo_write), 1);
        cycle();
        check("t2b_busy_one_cycle", 32'(bus.o_busy), 0);

        // 3: FIFO full for 10 cycles mid-frame on producer 2
        apply_reset();
        queue_frame(2, 32'b110010, 6);
        for (int k = 0; k < 20 && wr_cnt < 2; k++) cycle();
        check("t3_first_bits", wr_cnt, 2);
        full_cfg = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            check("t3_no_write_full", 32'(bus.o_fifo_write), 0);
            check("t3_ready_low", 32'(bus.o_req_ready), 0);
            check("t3_no_abort", 32'(bus.o_abort), 0);
            check("t3_still_busy", 32'(bus.o_busy), 1);
        end
        full_cfg = 1'b0;
        for (int k = 0; k < 40 && !all_done(); k++) cycle();
        check("t3_write_count", wr_cnt, 6);
        check("t3_abort_count", abort_cnt, 0);
        check("t3_sb_empty", exp_q[2].size(), 0);

        // 4: producer 1 goes silent after two bits; timeout aborts, producer 2 is next
        apply_reset();
        queue_frame(1, 32'b10101, 5);
        for (int k = 0; k < 20 && wr_cnt < 2; k++) cycle();
        check("t4_first_bits", wr_cnt, 2);
        hold[1] = 1'b1;
        queue_frame(0, 32'b01, 2);
        queue_frame(2, 32'b110, 3);
        for (int i = 0; i < TMO; i++) begin
            cycle();
            check("t4_stall_busy", 32'(bus.o_busy), 1);
            check("t4_stall_no_abort", 32'(bus.o_abort), 0);
            check("t4_others_ignored", 32'(bus.o_grant), 32'h2);
            check("t4_stall_no_write", 32'(bus.o_fifo_write), 0);
        end
        cycle();
        check("t4_aborted_idle", 32'(bus.o_busy), 0);
        check("t4_abort_pulse", 32'(bus.o_abort), 1);
        flush(1);
        hold[1] = 1'b0;
        cycle();
        check("t4_next_grant", 32'(bus.o_grant), 32'h4);
        check("t4_abort_one_cycle", 32'(bus.o_abort), 0);
        for (int k = 0; k < 40 && !all_done(); k++) cycle();
        check("t4_write_count", wr_cnt, 7);
        check("t4_abort_count", abort_cnt, 1);

        // 5: reset asserted mid-frame on producer 3
        apply_reset();
        queue_frame(3, 32'b101101, 6);
        for (int k = 0; k < 20 && wr_cnt < 2; k++) cycle();
        check("t5_first_bits", wr_cnt, 2);
        rst = 1'b1;
        #1;
        check("t5_rst_grant", 32'(bus.o_grant), 0);
        check("t5_rst_busy", 32'(bus.o_busy), 0);
        check("t5_rst_write", 32'(bus.o_fifo_write), 0);
        flush(3);
        drive_idle();
        clear_monitor();
        @(posedge clk);
        #1 rst = 1'b0;
        queue_frame(0, 32'b011, 3);
        queue_frame(3, 32'b10, 2);
        for (int k = 0; k < 40 && !all_done(); k++) cycle();
        check("t5_grant_count", grant_log.size(), 2);
        check("t5_first_winner", grant_log[0], 0);
        check("t5_second_winner", grant_log[1], 3);
        check("t5_write_count", wr_cnt, 5);

        // 6: random frames with random backpressure
        apply_reset();
        total = 0;
        for (int p = 0; p < N; p++) begin
            for (int f = 0; f < 6; f++) begin
                int len;
                len = $urandom_range(1, 6);
                queue_frame(p, $urandom, len);
                total += len;
            end
        end
        stress = 1'b1;
        for (int k = 0; k < 3000 && !all_done(); k++) cycle();
        stress = 1'b0;
        check("t6_done", 32'(all_done()), 1);
        check("t6_write_count", wr_cnt, total);
        check("t6_abort_count", abort_cnt, 0);
        check("t6_bubbles", bubble_viol, 0);
        for (int p = 0; p < N; p++) check("t6_sb_empty", exp_q[p].size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
